// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the regfile write port between pipeline writeback (A) and a FIFO of long-latency results (B)
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_we,
  input  logic [4:0]  a_waddr,
  input  logic [31:0] a_wdata,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_waddr,
  input  logic [31:0] b_wdata,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic [31:0] busy_mask,
  output logic        stall_req,
  output logic        err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [4:0]    q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;
  logic          a_take, push, pop, empty;
  assign empty   = count == '0;
  assign b_ready = count != CW'(DEPTH);
  assign a_take  = a_we & (a_waddr != '0);
  // r0 results complete the handshake but are dropped here
  assign push    = b_valid & b_ready & (b_waddr != '0);
  assign pop     = !a_take & !empty;
  always_comb begin
    busy_mask = '0;
    for (int k = 0; k < DEPTH; k++)
      if (CW'(k) < count) busy_mask[q_addr[rd_ptr + PW'(k)]] = 1'b1;
  end
  always_ff @(posedge clk)
    if (push) begin
      q_addr[wr_ptr] <= b_waddr;
      q_data[wr_ptr] <= b_wdata;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      starve    <= '0;
      stall_req <= 1'b0;
      err       <= 1'b0;
    end else begin
      we        <= a_take | pop;
      waddr     <= a_take ? a_waddr : pop ? q_addr[rd_ptr] : '0;
      wdata     <= a_take ? a_wdata : pop ? q_data[rd_ptr] : '0;
      rd_ptr    <= rd_ptr + PW'(pop);
      wr_ptr    <= wr_ptr + PW'(push);
      count     <= count + CW'(push) - CW'(pop);
      starve    <= (pop | empty) ? '0 : (a_take && starve != SW'(STARVE_MAX)) ? starve + 1'b1 : starve;
      stall_req <= !pop & (stall_req | (starve == SW'(STARVE_MAX)));
      // a write that A is allowed to make while stalled is not a hazard
      err       <= err | (a_take & busy_mask[a_waddr] & !stall_req);
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random checks of the writeback arbiter against a queue-based model
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int STARVE_MAX = 4;
  logic clk, rst, a_we, b_valid, b_ready, we, stall_req, err;
  logic [4:0] a_waddr, b_waddr, waddr;
  logic [31:0] a_wdata, b_wdata, wdata, busy_mask;
  int checks = 0, failures = 0;
  logic [36:0] mq[$];
  logic m_we, m_stall, m_err;
  logic [4:0] m_waddr;
  logic [31:0] m_wdata;
  int m_blocked;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
    .we(we), .waddr(waddr), .wdata(wdata), .busy_mask(busy_mask),
    .stall_req(stall_req), .err(err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) m[mq[i][36:32]] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_stall = 1'b0; m_err = 1'b0; m_blocked = 0;
  endtask

  task automatic model_edge();
    bit a_take, pop, was_empty, was_full;
    logic [36:0] head;
    a_take = a_we && a_waddr != 0;
    was_empty = mq.size() == 0;
    was_full = mq.size() == DEPTH;
    pop = !a_take && !was_empty;
    m_err = m_err | (a_take && model_mask()[a_waddr] && !m_stall);
    m_stall = !pop && (m_stall || m_blocked == STARVE_MAX);
    if (pop || was_empty) m_blocked = 0;
    else if (a_take && m_blocked < STARVE_MAX) m_blocked++;
    if (a_take) begin
      m_we = 1'b1; m_waddr = a_waddr; m_wdata = a_wdata;
    end else if (pop) begin
      head = mq.pop_front();
      m_we = 1'b1; m_waddr = head[36:32]; m_wdata = head[31:0];
    end else begin
      m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    end
    if (b_valid && !was_full && b_waddr != 0) mq.push_back({b_waddr, b_wdata});
  endtask

  // called at a falling edge: drive, compare against model, advance one clock
  task automatic cycle(input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    a_we = aw; a_waddr = aa; a_wdata = ad;
    b_valid = bv; b_waddr = ba; b_wdata = bd;
    #1;
    chk("b_ready", 32'(b_ready), 32'(mq.size() != DEPTH));
    chk("busy_mask", busy_mask, model_mask());
    chk("we", 32'(we), 32'(m_we));
    chk("waddr", 32'(waddr), 32'(m_waddr));
    chk("wdata", wdata, m_wdata);
    chk("stall_req", 32'(stall_req), 32'(m_stall));
    chk("err", 32'(err), 32'(m_err));
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    a_we = 1'b0; b_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; a_we = 0; a_waddr = 0; a_wdata = 0; b_valid = 0; b_waddr = 0; b_wdata = 0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("init_waddr", 32'(waddr), 32'd0);
    chk("init_wdata", wdata, 32'd0);
    cycle(1, 5, 32'h1234, 0, 0, 0);
    chk("a_we", 32'(we), 32'd1);
    chk("a_waddr", 32'(waddr), 32'd5);
    chk("a_wdata", wdata, 32'h1234);
    cycle(0, 0, 0, 0, 0, 0);
    chk("a_done", 32'(we), 32'd0);
    cycle(0, 0, 0, 1, 7, 32'hDEAD);
    chk("b_busy", busy_mask, 32'h80);
    chk("b_not_yet", 32'(we), 32'd0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("b_we", 32'(we), 32'd1);
    chk("b_waddr", 32'(waddr), 32'd7);
    chk("b_wdata", wdata, 32'hDEAD);
    chk("b_busy_clear", busy_mask, 32'd0);
    cycle(1, 1, 32'h11, 1, 3, 32'h33);
    cycle(1, 2, 32'h22, 1, 4, 32'h44);
    chk("full_b_ready", 32'(b_ready), 32'd0);
    chk("full_busy", busy_mask, 32'h18);
    for (int i = 0; i < 4; i++) cycle(1, 5'(1 + i % 2), 32'(i), 0, 0, 0);
    chk("starve_stall", 32'(stall_req), 32'd1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("drain1_addr", 32'(waddr), 32'd3);
    chk("drain1_data", wdata, 32'h33);
    chk("drain1_stall", 32'(stall_req), 32'd0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("drain2_addr", 32'(waddr), 32'd4);
    chk("drain2_data", wdata, 32'h44);
    cycle(0, 0, 0, 1, 0, 32'hBAD);
    chk("r0_b_ready", 32'(b_ready), 32'd1);
    chk("r0_busy", busy_mask, 32'd0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("r0_no_write", 32'(we), 32'd0);
    cycle(0, 0, 0, 1, 9, 32'h99);
    chk("r9_busy", busy_mask, 32'h200);
    cycle(1, 9, 32'h77, 0, 0, 0);
    chk("hazard_err", 32'(err), 32'd1);
    chk("hazard_waddr", 32'(waddr), 32'd9);
    chk("hazard_wdata", wdata, 32'h77);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
    chk("err_sticky", 32'(err), 32'd1);
    do_reset();
    cycle(1, 1, 32'h1, 1, 10, 32'hA);
    cycle(1, 2, 32'h2, 1, 11, 32'hB);
    chk("pre_rst_we", 32'(we), 32'd1);
    chk("pre_rst_busy", busy_mask, 32'hC00);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
    chk("post_rst_idle", 32'(we), 32'd0);
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset();
      cycle($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single regfile write port between two sources. Port A is the in-order pipeline writeback. Port B is the long-latency unit result path (mul/div, later uncached loads).
- B results are buffered in a small FIFO and drained into idle writeback slots.
- The block publishes a pending-write mask for hazard detection.
- It raises a pipeline stall when B is starved.
- Sits between the MEM/WB stage and regfile's we/waddr/wdata inputs.

Parameters:
DEPTH, 2, FIFO entries for port B results (power of 2, 2..8)
STARVE_MAX, 4, consecutive cycles a non-empty FIFO may be blocked by port A before stall_req asserts

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
a_we  in  1  pipeline writeback enable
a_waddr  in  5  pipeline writeback register address
a_wdata  in  32  pipeline writeback data
b_valid  in  1  long-latency result valid
b_ready  out  1  arbiter can accept B result
b_waddr  in  5  B destination register
b_wdata  in  32  B result data
we  out  1  regfile write enable (registered)
waddr  out  5  regfile write address (registered)
wdata  out  32  regfile write data (registered)
busy_mask  out  32  bit n set while a write to reg n is queued in FIFO
stall_req  out  1  request pipeline to stall so the FIFO can drain (registered)
err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst=1): we=0, waddr=0, wdata=0, stall_req=0, err=0. FIFO empty, starve counter=0, so b_ready=1 and busy_mask=0 immediately.
- b_ready = (count != DEPTH), derived from registered count only. No combinational path from a_we or from the drain decision. When full, b_ready=0 even in a cycle where an entry drains.
- B accept: b_valid & b_ready at edge t pushes {b_waddr, b_wdata}.
  - b_waddr==0: accepted (handshake completes) but discarded, not queued.
  - b_valid with b_ready=0: no push. The source must hold its values.
- Output slot selection each cycle, in priority order:
  - a_we=1 and a_waddr!=0: register A (we=1, waddr/wdata from A).
  - Otherwise, FIFO non-empty: pop head into the output registers (we=1).
  - Otherwise: we=0, waddr=0, wdata=0.
  - a_we=1 with a_waddr=0 counts as idle (slot free for FIFO).
- Latency:
  - A presented in cycle t: regfile sees it in cycle t+1.
  - B accepted at edge t with FIFO empty and A idle in cycle t+1: regfile sees it in cycle t+2.
- Push and pop in the same cycle are both performed; count is unchanged.
- FIFO drains strictly in order. Pointers wrap modulo DEPTH.
- busy_mask: combinational OR of one-hot(addr) over valid FIFO entries only. An entry popped into the output register is no longer in the mask. Bit 0 is always 0.
- err: set and held until reset when a_we=1 & a_waddr!=0 & busy_mask[a_waddr]=1. This is a pipeline hazard violation. A is still written normally.
- Starvation:
  - Counter increments on each cycle where the FIFO is non-empty and A takes the slot.
  - Counter clears on any pop, and whenever the FIFO is empty.
  - When counter==STARVE_MAX, stall_req is registered to 1.
  - stall_req holds until the cycle after the next pop, then returns to 0 and the counter resets.
  - The pipeline must deassert a_we while stalled. A a_we=1 during stall_req=1 is still honoured (A wins) and does not set err.
- Reset mid-operation: FIFO contents are lost, in-flight output write is killed (we=0 asynchronously), stall_req drops.

Test Plan:
- Reset, then a_we=1 a_waddr=5 a_wdata=0x1234 for 1 cycle -> next cycle we=1 waddr=5 wdata=0x1234; the cycle after, we=0.
- A idle; B pushes (7, 0xDEAD) at edge t -> busy_mask=0x80 after t; cycle t+2 we=1 waddr=7 wdata=0xDEAD; busy_mask=0 once popped.
- DEPTH=2: B pushes r3, r4 while a_we=1 every cycle -> b_ready=0 after 2nd push. After STARVE_MAX=4 blocked cycles stall_req=1. Then a_we=0 -> r3 written, next cycle r4, stall_req=0 after first pop.
- B push to r0 -> b_ready stays 1, busy_mask stays 0, no regfile write ever issued.
- busy_mask[9]=1 and a_we=1 a_waddr=9 -> err=1 and stays 1 until rst; regfile still gets A's write.
- Assert rst asynchronously with 2 FIFO entries and we=1 -> we, stall_req, busy_mask drop to 0 immediately; b_ready=1; no queued write appears after reset release.
